// File: rtl/instr_fetch.sv
// LEGv8 instruction fetch sequencer: owns the PC, fetches over req/ack and presents over valid/ready.
// Optional FETCH_HALT_EN: an accepted all-zero instruction word parks the block in S_HALT until reset.
module instr_fetch #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [10:0]     opcode,
  output logic [PC_W-1:0] pc_out,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_base,
  input  logic [25:0]     redirect_offset
);

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
`endif

  state_t          state;
  logic [PC_W-1:0] pc;
  logic            squash;
  logic [PC_W-1:0] ext_offset;
  logic [PC_W-1:0] target;

  // Word offset is sign-extended and scaled to bytes; the sum wraps modulo 2^PC_W.
  assign ext_offset = {{(PC_W-26){redirect_offset[25]}}, redirect_offset};
  assign target     = redirect_base + {ext_offset[PC_W-3:0], 2'b00};
  assign opcode     = instr[31:21];

  // Outputs are registered; a request in S_REQ with imem_req low is the
  // one-cycle gap that follows a squashed ack, and the next edge re-issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      pc_out      <= RESET_PC;
      squash      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
          if (redirect) begin
            pc        <= target;
            imem_addr <= target;
          end else begin
            imem_addr <= pc;
          end
        end

        S_REQ: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
            if (redirect) begin
              pc        <= target;
              imem_addr <= target;
            end else begin
              imem_addr <= pc;
            end
          end else if (imem_ack) begin
            imem_req <= 1'b0;
            squash   <= 1'b0;
            if (redirect) begin
              pc <= target;
            end else if (!squash) begin
              instr       <= imem_rdata;
              pc_out      <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + PC_W'(4);
              state       <= S_HOLD;
            end
          end else if (redirect) begin
            // The outstanding address stays on the bus; its data is dropped on ack.
            pc     <= target;
            squash <= 1'b1;
          end
        end

        S_HOLD: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            pc          <= target;
            imem_req    <= 1'b1;
            imem_addr   <= target;
            state       <= S_REQ;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
`ifdef FETCH_HALT_EN
            if (instr == 32'h0000_0000) begin
              state <= S_HALT;
            end else begin
              imem_req  <= 1'b1;
              imem_addr <= pc;
              state     <= S_REQ;
            end
`else
            imem_req  <= 1'b1;
            imem_addr <= pc;
            state     <= S_REQ;
`endif
          end
        end

`ifdef FETCH_HALT_EN
        S_HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch sequencer that produces the 32-bit instruction stream consumed by the LEGv8 control decoder and datapath. It owns the PC, runs a req/ack handshake against instruction memory, and presents one instruction at a time to the decode stage over a valid/ready handshake. It also exposes opcode field [31:21] directly for the control unit. Branch redirects resolved downstream (CBZ/B) reload the PC and squash in-flight or held instructions.

Parameters:
PC_W, 64, PC and address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
imem_req  out  1  fetch request to instruction memory
imem_addr  out  PC_W  fetch address, byte address, word aligned
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  instr/opcode/pc_out valid to decode
instr_ready  in  1  decode accepts instruction
instr  out  32  held instruction word
opcode  out  11  instr[31:21], feeds control decoder
pc_out  out  PC_W  PC of held instruction
redirect  in  1  one-cycle pulse, branch taken
redirect_base  in  PC_W  PC of the branch instruction
redirect_offset  in  26  signed word offset (imm26 or sign-extended imm19)

Behaviour:
- Reset (rst_n low, async): state S_IDLE; pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; instr_valid=0; instr=0; opcode=0; pc_out=RESET_PC; squash=0. Reset mid-operation aborts everything immediately; an ack arriving during/after reset for the aborted request is ignored.
- States: S_IDLE, S_REQ, S_HOLD, S_HALT (S_HALT only with macro).
- S_IDLE: unconditionally -> S_REQ next cycle.
- S_REQ: imem_req=1, imem_addr=pc, both held stable until imem_ack. On ack with squash=0: instr<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+4, -> S_HOLD. Latency: ack in cycle n -> instr_valid high in cycle n+1. Ack in the same cycle req first rises is legal.
- S_HOLD: imem_req=0; instr, opcode, pc_out stable while instr_valid=1 and instr_ready=0. Handshake = instr_valid & instr_ready -> instr_valid<=0, -> S_REQ (next request at pc, i.e. previous +4).
- Redirect target = (redirect_base + (sext(redirect_offset) << 2)) mod 2^PC_W; wrap-around permitted, no alignment check.
- Redirect in S_HOLD: pc<=target, instr_valid<=0, -> S_REQ; held instruction dropped. If it coincides with an accepting handshake, the instruction counts as consumed and the PC still takes target.
- Redirect in S_REQ without ack: pc<=target, squash<=1; request keeps old address until ack; that ack's data discarded (no instr_valid), squash<=0, stay S_REQ issuing target next cycle (req deasserted for one cycle).
- Redirect in S_REQ with ack in same cycle: data discarded, pc<=target, stay S_REQ.
- Redirect in S_IDLE: pc<=target. Redirect ignored in S_HALT.
- pc arithmetic modulo 2^PC_W; pc+4 at max wraps to 0.
- opcode is always instr[31:21].

Optional Feature:
FETCH_HALT_EN: defined -> a captured word of 32'h00000000 is presented normally; on its acceptance the block enters S_HALT: imem_req=0, instr_valid=0, redirect ignored, exit only by reset. Undefined -> zero word handled like any other instruction; S_HALT absent.

Test Plan:
- Reset release, ack same cycle, rdata=32'hF8400000 -> imem_addr=0, instr_valid next cycle, opcode=11'b11111000010, pc_out=0; after ready, next imem_addr=4.
- Backpressure: instr_ready low 5 cycles -> instr/pc_out stable, imem_req=0 throughout; ready high -> next fetch at pc_out+4.
- Redirect in S_HOLD, base=0x10, offset=-2 -> instr_valid drops next cycle, next imem_addr=0x08.
- Redirect while request pending, ack 3 cycles later -> returned data never presented, one idle cycle, then imem_addr=target.
- rst_n low mid-request -> all outputs at reset values immediately; restart fetch at RESET_PC; pc wrap test from 2^PC_W-4 -> 0.
- FETCH_HALT_EN: fetch 32'h0, accept -> imem_req stays 0, redirect ignored; without macro fetch continues at +4.
